// File: rtl/knn_local_buf_streamer.sv
// knn_local_buf_streamer: streams a contiguous, wrap-around range of words
// out of the per-PE URAM local buffer onto a valid/ready stream. Reads are
// issued only when the output FIFO is guaranteed to have room for them, so
// back-pressure never loses or duplicates a word.
module knn_local_buf_streamer #(
  parameter int DataWidth    = 256,
  parameter int AddressWidth = 11,
  parameter int AddressRange = 2048,
  parameter int ReadLatency  = 2,
  parameter int FifoDepth    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [AddressWidth-1:0] base_addr,
  input  logic [AddressWidth:0]   num_words,
  output logic                    busy,
  output logic                    done,
  output logic [DataWidth-1:0]    out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [AddressWidth-1:0] mem_address0,
  output logic                    mem_ce0,
  output logic                    mem_we0,
  output logic [DataWidth-1:0]    mem_d0,
  input  logic [DataWidth-1:0]    mem_q0
);

  localparam int PW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CW = $clog2(FifoDepth + ReadLatency + 1);
  localparam logic [AddressWidth:0] MaxWords = (AddressWidth+1)'(AddressRange);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  typedef struct packed {
    logic                 last;
    logic [DataWidth-1:0] data;
  } word_t;

  state_t                  state;
  logic [AddressWidth-1:0] base_q;
  logic [AddressWidth:0]   num_q;
  logic [AddressWidth:0]   issued;

  // vld_pipe[k] is set for a read issued k cycles ago; last_pipe rides along
  logic [ReadLatency:1]    vld_pipe;
  logic [ReadLatency:1]    last_pipe;

  word_t                   fifo_mem [FifoDepth];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           fifo_cnt;
  logic [CW-1:0]           inflight;

  logic credit, issue, issue_last, push, pop;

  // Reads still travelling through the memory pipeline
  always_comb begin
    inflight = '0;
    for (int k = 1; k <= ReadLatency; k++) inflight = inflight + CW'(vld_pipe[k]);
  end

  // A same-cycle pop is deliberately not credited: keeps the FIFO overflow-free
  assign credit     = (inflight + fifo_cnt) < CW'(FifoDepth);
  assign issue      = (state == ISSUE) && credit;
  assign issue_last = (issued == num_q - 1'b1);
  assign push       = vld_pipe[ReadLatency];

  assign out_valid  = (fifo_cnt != '0);
  assign pop        = out_valid & out_ready;
  assign out_data   = out_valid ? fifo_mem[rd_ptr].data : '0;
  assign out_last   = out_valid & fifo_mem[rd_ptr].last;

  assign mem_ce0      = issue;
  assign mem_address0 = issue ? (base_q + issued[AddressWidth-1:0]) : '0;
  assign mem_we0      = 1'b0;
  assign mem_d0       = '0;

  assign busy = (state == ISSUE) || (state == DRAIN);
  assign done = (state == FIN);

  // Transfer sequencing; FIN also accepts a new start so transfers can chain
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      base_q <= '0;
      num_q  <= '0;
      issued <= '0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (start) begin
            base_q <= base_addr;
            num_q  <= (num_words > MaxWords) ? MaxWords : num_words;
            issued <= '0;
            state  <= (num_words != '0) ? ISSUE : FIN;
          end else begin
            state  <= IDLE;
          end
        end
        ISSUE: begin
          if (issue) begin
            issued <= issued + 1'b1;
            if (issue_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && out_last) state <= FIN;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Track in-flight reads; clearing on reset drops their data on arrival
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe[1]  <= issue;
      last_pipe[1] <= issue & issue_last;
      for (int k = 2; k <= ReadLatency; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        last_pipe[k] <= last_pipe[k-1];
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(FifoDepth-1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(FifoDepth-1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage; contents are qualified by fifo_cnt so no reset is needed
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{last: last_pipe[ReadLatency], data: mem_q0};
  end

endmodule

// File: tb/tb_knn_local_buf_streamer.sv
// Testbench for knn_local_buf_streamer: memory model with 2-cycle latency,
// table of transfers plus randomized transfers, reset and chaining sequences.
module tb_knn_local_buf_streamer;
  localparam int DW = 256;
  localparam int AW = 11;
  localparam int DEPTH = 2048;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_words = '0;
  logic          busy, done, out_valid, out_last, mem_ce0, mem_we0;
  logic [DW-1:0] out_data, mem_d0, mem_q0;
  logic [AW-1:0] mem_address0;

  knn_local_buf_streamer dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .mem_address0(mem_address0), .mem_ce0(mem_ce0), .mem_we0(mem_we0),
    .mem_d0(mem_d0), .mem_q0(mem_q0)
  );

  always #5 clk = ~clk;

  // Memory model: data for a read in cycle t is on mem_q0 during cycle t+2
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] ram_p1;
  always @(posedge clk) begin
    if (mem_ce0) ram_p1 <= ram[mem_address0];
    mem_q0 <= ram_p1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] d; bit l; } word_t;
  word_t got_q[$];
  int    ce_addr_q[$];
  int    ce_cyc_q[$];
  int    done_q[$];
  int    t0, busy_cnt, max_occ, stab_bad, fv_cyc, rdy_mode;
  bit    fv_seen;
  int    total = 0, bad = 0;

  logic          prev_v = 0, prev_r = 0, prev_l = 0, prev_rst = 1;
  logic [DW-1:0] prev_d = '0;

  // Passive observer of the DUT pins
  always @(negedge clk) begin
    int occ;
    occ = ce_cyc_q.size() - got_q.size();
    if (mem_ce0 && occ + 1 > max_occ) max_occ = occ + 1;
    if (!reset && !prev_rst && prev_v && !prev_r &&
        (!out_valid || out_data != prev_d || out_last != prev_l)) stab_bad++;
    if (mem_ce0) begin ce_addr_q.push_back(int'(mem_address0)); ce_cyc_q.push_back(cyc); end
    if (out_valid && !fv_seen) begin fv_seen = 1; fv_cyc = cyc; end
    if (out_valid && out_ready) got_q.push_back('{d: out_data, l: out_last});
    if (done) done_q.push_back(cyc);
    if (busy) busy_cnt++;
    prev_v = out_valid; prev_r = out_ready; prev_d = out_data;
    prev_l = out_last; prev_rst = reset;
  end

  // Consumer: always ready, 10-cycle stall after first word, or random
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      1:       out_ready = fv_seen && (cyc - fv_cyc) > 10;
      2:       out_ready = ($urandom_range(3) != 0);
      default: out_ready = 1'b1;
    endcase
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_obs();
    got_q.delete(); ce_addr_q.delete(); ce_cyc_q.delete(); done_q.delete();
    busy_cnt = 0; max_occ = 0; stab_bad = 0; fv_seen = 0;
  endtask

  // Compare observed stream and issued addresses against the plain range model
  task automatic check_stream(input string nm, input int base, input int num, input int wofs);
    int nerr, first;
    nerr = 0; first = -1;
    for (int i = 0; i < num; i++) begin
      int a;
      a = (base + i) % DEPTH;
      if (wofs + i >= got_q.size() || wofs + i >= ce_addr_q.size() ||
          got_q[wofs+i].d != ram[a] || got_q[wofs+i].l != (i == num - 1) ||
          ce_addr_q[wofs+i] != a) begin
        nerr++;
        if (first < 0) first = i;
      end
    end
    total++;
    if (nerr != 0) begin
      bad++;
      $display("FAIL %s_stream: %0d bad words, first at index %0d, expected 0 bad", nm, nerr, first);
    end
  endtask

  task automatic run_xfer(input int base, input int num, input int mode, input bit spur,
                          input int exp_done, input int exp_fv);
    int n, budget;
    rdy_mode = mode;
    clear_obs();
    @(posedge clk); #1;
    start = 1; base_addr = AW'(base); num_words = (AW+1)'(num); t0 = cyc;
    n = 0; budget = 4 * num + 60;
    do begin
      @(posedge clk); #1; n++;
      start = spur && ((cyc - t0) == 3 || (cyc - t0) == 6);
      if (start) begin base_addr = AW'(500); num_words = (AW+1)'(7); end
    end while (done_q.size() == 0 && n < budget);
    start = 0;
    repeat (2) @(posedge clk); #1;
    chk("done_count", done_q.size(), 1);
    if (exp_done >= 0 && done_q.size() > 0) chk("done_cycle", done_q[0] - t0, exp_done);
    if (exp_done >= 0) chk("busy_cycles", busy_cnt, exp_done - 1);
    if (exp_fv >= 0) begin
      chk("first_valid_cycle", fv_seen ? fv_cyc - t0 : -1, exp_fv);
      chk("first_ce_cycle", ce_cyc_q.size() > 0 ? ce_cyc_q[0] - t0 : -1, 1);
    end
    chk("word_count", got_q.size(), num);
    chk("issue_count", ce_addr_q.size(), num);
    check_stream("xfer", base, num, 0);
    chk("occupancy_le_depth", max_occ <= 4, 1);
    if (mode == 1) chk("occupancy_reaches_depth", max_occ, 4);
    chk("hold_stable", stab_bad, 0);
  endtask

  typedef struct {
    int base; int num; int mode; bit spur; int exp_done; int exp_fv;
  } vec_t;

  initial begin
    vec_t vecs[7];
    rdy_mode = 0;
    for (int i = 0; i < DEPTH; i++) ram[i] = {8{$urandom()}};
    ram_p1 = '0;

    vecs[0] = '{base: 0,    num: 4,    mode: 0, spur: 0, exp_done: 8,    exp_fv: 4};
    vecs[1] = '{base: 0,    num: 0,    mode: 0, spur: 0, exp_done: 1,    exp_fv: -1};
    vecs[2] = '{base: 2046, num: 4,    mode: 0, spur: 0, exp_done: 8,    exp_fv: 4};
    vecs[3] = '{base: 37,   num: 16,   mode: 1, spur: 0, exp_done: -1,   exp_fv: -1};
    vecs[4] = '{base: 1000, num: 9,    mode: 0, spur: 1, exp_done: 13,   exp_fv: 4};
    vecs[5] = '{base: 5,    num: 1,    mode: 0, spur: 0, exp_done: 5,    exp_fv: 4};
    vecs[6] = '{base: 0,    num: 2048, mode: 0, spur: 0, exp_done: 2052, exp_fv: 4};

    // Power-on reset
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("reset_outputs_zero",
        {busy, done, out_valid, out_last, mem_ce0, mem_we0} == 6'b0 &&
        out_data == '0 && mem_address0 == '0 && mem_d0 == '0, 1);

    foreach (vecs[i])
      run_xfer(vecs[i].base, vecs[i].num, vecs[i].mode, vecs[i].spur,
               vecs[i].exp_done, vecs[i].exp_fv);

    for (int r = 0; r < 6; r++)
      run_xfer($urandom_range(DEPTH - 1), $urandom_range(40, 1), 2, 0, -1, -1);

    // Reset in cycle 3 of an 8-word transfer
    rdy_mode = 0;
    clear_obs();
    @(posedge clk); #1;
    start = 1; base_addr = AW'(300); num_words = (AW+1)'(8); t0 = cyc;
    @(posedge clk); #1 start = 0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    fv_seen = 0;
    @(negedge clk);
    chk("midrun_reset_outputs_zero",
        {busy, done, out_valid, out_last, mem_ce0} == 5'b0 &&
        out_data == '0 && mem_address0 == '0, 1);
    repeat (12) @(negedge clk);
    chk("discarded_reads_never_valid", fv_seen, 0);
    run_xfer(100, 2, 0, 0, 6, 4);

    // Start accepted in the done cycle: two transfers back to back
    rdy_mode = 0;
    clear_obs();
    @(posedge clk); #1;
    start = 1; base_addr = AW'(10); num_words = (AW+1)'(3); t0 = cyc;
    @(posedge clk); #1 start = 0;
    while (cyc - t0 < 7) begin @(posedge clk); #1; end
    start = 1; base_addr = AW'(20); num_words = (AW+1)'(2);
    @(posedge clk); #1 start = 0;
    repeat (10) @(posedge clk); #1;
    chk("chain_done_count", done_q.size(), 2);
    if (done_q.size() == 2) begin
      chk("chain_done1_cycle", done_q[0] - t0, 7);
      chk("chain_done2_cycle", done_q[1] - t0, 13);
    end
    chk("chain_word_count", got_q.size(), 5);
    check_stream("chain_a", 10, 3, 0);
    check_stream("chain_b", 20, 2, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
